// File: rtl/cp0_exception_sequencer.sv
// Sequences the CP0 read-modify-write traffic for exception entry and ERET over the
// single exception-side CP0 port, then issues one fetch redirect per accepted request.
module cp0_exception_sequencer #(
    parameter logic [31:0] BEV_VECTOR = 32'hBFC0_0380,
    parameter logic [31:0] EXC_OFFSET = 32'h0000_0180
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_is_eret,
    input  logic [4:0]  req_exc_code,
    input  logic [31:0] req_pc,
    input  logic        req_bd,
    input  logic        req_has_badva,
    input  logic [31:0] req_badva,
    output logic [4:0]  cp0_addr,
    output logic [2:0]  cp0_sel,
    output logic        cp0_wen,
    output logic [31:0] cp0_wdata,
    input  logic [31:0] cp0_rdata,
    output logic        busy,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc
);

    typedef enum logic [3:0] {
        StIdle, StStRd, StEpc, StCause, StBadva, StStWr, StVec, StRetRd, StRedir
    } state_e;

    state_e      state_q, state_d;
    logic        is_eret_q, is_eret_d;
    logic [4:0]  exc_code_q, exc_code_d;
    logic [31:0] pc_q, pc_d;
    logic        bd_q, bd_d;
    logic        has_badva_q, has_badva_d;
    logic [31:0] badva_q, badva_d;
    logic        exl_q, exl_d;
    logic        bev_q, bev_d;
    logic        erl_q, erl_d;
    logic [31:0] target_q, target_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            is_eret_q   <= 1'b0;
            exc_code_q  <= 5'd0;
            pc_q        <= 32'd0;
            bd_q        <= 1'b0;
            has_badva_q <= 1'b0;
            badva_q     <= 32'd0;
            exl_q       <= 1'b0;
            bev_q       <= 1'b0;
            erl_q       <= 1'b0;
            target_q    <= 32'd0;
        end else begin
            state_q     <= state_d;
            is_eret_q   <= is_eret_d;
            exc_code_q  <= exc_code_d;
            pc_q        <= pc_d;
            bd_q        <= bd_d;
            has_badva_q <= has_badva_d;
            badva_q     <= badva_d;
            exl_q       <= exl_d;
            bev_q       <= bev_d;
            erl_q       <= erl_d;
            target_q    <= target_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        is_eret_d   = is_eret_q;
        exc_code_d  = exc_code_q;
        pc_d        = pc_q;
        bd_d        = bd_q;
        has_badva_d = has_badva_q;
        badva_d     = badva_q;
        exl_d       = exl_q;
        bev_d       = bev_q;
        erl_d       = erl_q;
        target_d    = target_q;
        unique case (state_q)
            StIdle: begin
                if (req_valid) begin
                    is_eret_d   = req_is_eret;
                    exc_code_d  = req_exc_code;
                    pc_d        = req_pc;
                    bd_d        = req_bd;
                    has_badva_d = req_has_badva;
                    badva_d     = req_badva;
                    state_d     = StStRd;
                end
            end
            StStRd: begin
                exl_d   = cp0_rdata[1];
                erl_d   = cp0_rdata[2];
                bev_d   = cp0_rdata[22];
                state_d = is_eret_q ? StRetRd : StEpc;
            end
            StEpc:   state_d = StCause;
            StCause: state_d = has_badva_q ? StBadva : StStWr;
            StBadva: state_d = StStWr;
            StStWr:  state_d = is_eret_q ? StRedir : StVec;
            StVec: begin
                target_d = bev_q ? BEV_VECTOR : ({cp0_rdata[31:12], 12'h000} + EXC_OFFSET);
                state_d  = StRedir;
            end
            StRetRd: begin
                target_d = cp0_rdata;
                state_d  = StStWr;
            end
            StRedir: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        cp0_addr       = 5'd0;
        cp0_sel        = 3'd0;
        cp0_wen        = 1'b0;
        cp0_wdata      = 32'd0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'd0;
        req_ready      = (state_q == StIdle);
        busy           = (state_q != StIdle);
        unique case (state_q)
            StStRd: cp0_addr = 5'd12;
            StEpc: begin
                cp0_addr  = 5'd14;
                cp0_wen   = !exl_q;
                cp0_wdata = bd_q ? (pc_q - 32'd4) : pc_q;
            end
            StCause: begin
                cp0_addr  = 5'd13;
                cp0_wen   = 1'b1;
                // BD is only refreshed on the first (non-nested) exception
                cp0_wdata = {(exl_q ? cp0_rdata[31] : bd_q), cp0_rdata[30:7], exc_code_q,
                             cp0_rdata[1:0]};
            end
            StBadva: begin
                cp0_addr  = 5'd8;
                cp0_wen   = 1'b1;
                cp0_wdata = badva_q;
            end
            StStWr: begin
                cp0_addr = 5'd12;
                cp0_wen  = 1'b1;
                if (!is_eret_q)  cp0_wdata = cp0_rdata | 32'h2;
                else if (erl_q)  cp0_wdata = cp0_rdata & ~32'h4;
                else             cp0_wdata = cp0_rdata & ~32'h2;
            end
            StVec: begin
                cp0_addr = 5'd15;
                cp0_sel  = 3'd1;
            end
            StRetRd: cp0_addr = erl_q ? 5'd30 : 5'd14;
            StRedir: begin
                redirect_valid = 1'b1;
                redirect_pc    = target_q;
            end
            default: ;
        endcase
        // Reset suppresses the write of the state it interrupts
        if (rst) cp0_wen = 1'b0;
    end

endmodule

// File: tb/tb_cp0_exception_sequencer.sv
// Directed bench for cp0_exception_sequencer with a behavioural CP0 register file and a
// monitor recording writes, accepts and redirects.
module tb_cp0_exception_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_is_eret, req_bd, req_has_badva;
    logic [4:0]  req_exc_code;
    logic [31:0] req_pc, req_badva;
    logic [4:0]  cp0_addr;
    logic [2:0]  cp0_sel;
    logic        cp0_wen;
    logic [31:0] cp0_wdata, cp0_rdata;
    logic        busy, redirect_valid;
    logic [31:0] redirect_pc;

    localparam logic [7:0] IStatus = 8'd96, ICause = 8'd104, IEpc = 8'd112;
    localparam logic [7:0] IBadva = 8'd64, IEbase = 8'd121, IErrEpc = 8'd240;

    always #5 clk = ~clk;

    cp0_exception_sequencer dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_is_eret(req_is_eret),
        .req_exc_code(req_exc_code), .req_pc(req_pc), .req_bd(req_bd),
        .req_has_badva(req_has_badva), .req_badva(req_badva),
        .cp0_addr(cp0_addr), .cp0_sel(cp0_sel), .cp0_wen(cp0_wen),
        .cp0_wdata(cp0_wdata), .cp0_rdata(cp0_rdata),
        .busy(busy), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
    );

    // CP0 register file model indexed by {addr, sel}
    logic [31:0] regs [256];
    logic        pre_we = 1'b0;
    logic [7:0]  pre_idx = 8'd0;
    logic [31:0] pre_data = 32'd0;
    assign cp0_rdata = regs[{cp0_addr, cp0_sel}];

    always @(posedge clk) begin
        if (cp0_wen) regs[{cp0_addr, cp0_sel}] <= cp0_wdata;
        else if (pre_we) regs[pre_idx] <= pre_data;
    end

    int cyc = 0;
    int wr_count [32];
    int accept_count = 0, redir_count = 0;
    int accept_hist [64];
    int redir_hist [64];
    logic [31:0] redir_pc_hist [64];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!rst && cp0_wen) wr_count[cp0_addr] <= wr_count[cp0_addr] + 1;
        if (!rst && req_valid && req_ready) begin
            if (accept_count < 64) accept_hist[accept_count] <= cyc;
            accept_count <= accept_count + 1;
        end
        if (!rst && redirect_valid) begin
            if (redir_count < 64) begin
                redir_hist[redir_count]    <= cyc;
                redir_pc_hist[redir_count] <= redirect_pc;
            end
            redir_count <= redir_count + 1;
        end
    end

    int checks = 0, passed = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic preset(input logic [7:0] idx, input logic [31:0] v);
        @(negedge clk);
        pre_we = 1'b1; pre_idx = idx; pre_data = v;
        @(negedge clk);
        pre_we = 1'b0;
    endtask

    task automatic drive(input logic eret, input logic [4:0] code, input logic [31:0] pc,
                         input logic bd, input logic hb, input logic [31:0] bva);
        req_is_eret = eret; req_exc_code = code; req_pc = pc;
        req_bd = bd; req_has_badva = hb; req_badva = bva;
    endtask

    // Issue one request from idle, wait (bounded) for its redirect, check pc and latency
    task automatic run(input string tag, input logic [31:0] exp_pc, input int exp_lat);
        int r0;
        r0 = redir_count;
        @(negedge clk);
        req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        for (int i = 0; i < 20 && redir_count == r0; i++) @(negedge clk);
        chk({tag, "_redir_cnt"}, redir_count, r0 + 1);
        chk({tag, "_redir_pc"}, redir_pc_hist[r0], exp_pc);
        chk({tag, "_latency"}, redir_hist[r0] - accept_hist[accept_count - 1], exp_lat);
    endtask

    int s8, s12, s13, s14, r0, a0;

    initial begin
        rst = 1'b1; req_valid = 1'b0;
        drive(1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 32'd0);
        @(negedge clk); @(negedge clk);
        chk("rst_ready_busy", {30'd0, req_ready, busy}, 32'h2);
        chk("rst_strobes", {30'd0, cp0_wen, redirect_valid}, 32'h0);
        chk("rst_addr_sel", {24'd0, cp0_addr, cp0_sel}, 32'h0);
        chk("rst_wdata", cp0_wdata, 32'h0);
        chk("rst_redir_pc", redirect_pc, 32'h0);
        rst = 1'b0;

        // 1: first exception, BadVAddr written, EBase vector
        preset(IStatus, 32'h0); preset(ICause, 32'h0);
        preset(IEbase, 32'h8000_0000); preset(IEpc, 32'h0); preset(IBadva, 32'h0);
        drive(1'b0, 5'd4, 32'h8000_1000, 1'b0, 1'b1, 32'h1233);
        run("t1", 32'h8000_0180, 7);
        chk("t1_epc", regs[IEpc], 32'h8000_1000);
        chk("t1_cause", regs[ICause], 32'h10);
        chk("t1_badva", regs[IBadva], 32'h1233);
        chk("t1_status", regs[IStatus], 32'h2);

        // 2: delay slot, no BadVAddr
        preset(IStatus, 32'h0); preset(ICause, 32'h0);
        s8 = wr_count[8];
        drive(1'b0, 5'd8, 32'h8000_2004, 1'b1, 1'b0, 32'hDEAD_BEEF);
        run("t2", 32'h8000_0180, 6);
        chk("t2_epc", regs[IEpc], 32'h8000_2000);
        chk("t2_cause", regs[ICause], 32'h8000_0020);
        chk("t2_no_badva_wr", wr_count[8], s8);
        chk("t2_badva_kept", regs[IBadva], 32'h1233);

        // 3: nested exception with BEV set
        preset(IStatus, 32'h0040_0002);
        s14 = wr_count[14];
        drive(1'b0, 5'd10, 32'h8000_5000, 1'b0, 1'b0, 32'h0);
        run("t3", 32'hBFC0_0380, 6);
        chk("t3_epc_kept", regs[IEpc], 32'h8000_2000);
        chk("t3_no_epc_wr", wr_count[14], s14);
        chk("t3_cause", regs[ICause], 32'h8000_0028);
        chk("t3_status", regs[IStatus], 32'h0040_0002);

        // 4: ERET via EPC
        preset(IStatus, 32'h2); preset(IEpc, 32'h8000_3000);
        drive(1'b1, 5'd0, 32'h0, 1'b0, 1'b0, 32'h0);
        run("t4", 32'h8000_3000, 4);
        chk("t4_status", regs[IStatus], 32'h0);

        // 5: ERET via ErrorEPC
        preset(IStatus, 32'h6); preset(IErrEpc, 32'hBFC0_0000);
        run("t5", 32'hBFC0_0000, 4);
        chk("t5_status", regs[IStatus], 32'h2);

        // 6: reset while in CAUSE
        preset(IStatus, 32'h0); preset(ICause, 32'h0); preset(IEpc, 32'h0);
        r0 = redir_count;
        drive(1'b0, 5'd4, 32'h8000_6000, 1'b0, 1'b1, 32'h77);
        @(negedge clk);
        req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk); @(negedge clk);
        chk("t6_in_cause", {27'd0, cp0_addr}, 32'd13);
        s8 = wr_count[8]; s12 = wr_count[12]; s13 = wr_count[13];
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("t6_idle", {30'd0, req_ready, busy}, 32'h2);
        for (int i = 0; i < 10; i++) @(negedge clk);
        chk("t6_no_redir", redir_count, r0);
        chk("t6_no_writes", wr_count[8] + wr_count[12] + wr_count[13], s8 + s12 + s13);
        chk("t6_epc_done", regs[IEpc], 32'h8000_6000);
        chk("t6_cause_untouched", regs[ICause], 32'h0);

        // 7: request held through busy, re-accepted right after REDIR
        preset(IStatus, 32'h2); preset(IEpc, 32'h8000_4000);
        a0 = accept_count; r0 = redir_count;
        drive(1'b1, 5'd0, 32'h0, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        req_valid = 1'b1;
        @(negedge clk); @(negedge clk);
        chk("t7_busy", {30'd0, req_ready, busy}, 32'h1);
        for (int i = 0; i < 40 && accept_count < a0 + 2; i++) @(negedge clk);
        req_valid = 1'b0;
        chk("t7_accepts", accept_count, a0 + 2);
        chk("t7_gap", accept_hist[a0 + 1] - accept_hist[a0], 5);
        chk("t7_after_redir", accept_hist[a0 + 1] - redir_hist[r0], 1);
        for (int i = 0; i < 20 && redir_count < r0 + 2; i++) @(negedge clk);
        chk("t7_redirs", redir_count, r0 + 2);
        chk("t7_pc2", redir_pc_hist[r0 + 1], 32'h8000_4000);
        chk("t7_status", regs[IStatus], 32'h0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
